score_display: RTL and testbench

Downstream consumer of the whack-a-mole game core. It takes the core's `score`, `lives` and `state` outputs and drives a 4-digit multiplexed, active-low seven-segment display:
- digits 2..0: score in decimal, with leading zeros suppressed;
- digit 3: remaining lives.

Binary-to-BCD conversion is sequential (double-dabble), and the display updates atomically when each conversion completes.

---
 rtl/mole_pkg.sv | 20 ++
 rtl/bin2bcd_seq.sv | 59 +++++
 rtl/score_display.sv | 103 ++++++++++
 tb/tb_score_display.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mole_pkg.sv
// mole_pkg: game-state codes and active-low seven-segment constants
// shared by the whack-a-mole core and its display.
package mole_pkg;
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PLAY      = 3'd1,
        ST_LIFE_LOST = 3'd2,
        ST_ENDSCREEN = 3'd3
    } game_state_e;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_FONT [10] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10
    };

    function automatic logic [6:0] seg_font(input logic [3:0] d);
        return (d < 4'd10) ? SEG_FONT[d] : SEG_BLANK;
    endfunction
endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: 7-bit binary to 3-digit BCD, one double-dabble step per cycle.
// Digits are held stable after done until the next accepted start.
module bin2bcd_seq
    import mole_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [6:0] bin,
    output logic       busy,
    output logic       done,
    output logic [3:0] hund,
    output logic [3:0] tens,
    output logic [3:0] ones
);
    logic [18:0] sh_q, sh_d, adj;
    logic [2:0]  cnt_q, cnt_d;
    logic        busy_q, busy_d, done_q, done_d;

    always_comb begin
        adj = sh_q;
        for (int i = 0; i < 3; i++)
            adj[7+4*i +: 4] = (sh_q[7+4*i +: 4] >= 4'd5) ? sh_q[7+4*i +: 4] + 4'd3 : sh_q[7+4*i +: 4];
        sh_d   = sh_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        done_d = 1'b0;
        if (busy_q) begin
            sh_d   = adj << 1;
            cnt_d  = cnt_q + 3'd1;
            busy_d = cnt_q != 3'd6;
            done_d = cnt_q == 3'd6;
        end else if (start) begin
            sh_d   = {12'd0, bin};
            cnt_d  = 3'd0;
            busy_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sh_q   <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            sh_q   <= sh_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hund = sh_q[18:15];
    assign tens = sh_q[14:11];
    assign ones = sh_q[10:7];
endmodule

// File: rtl/score_display.sv
// score_display: multiplexed 4-digit active-low seven-segment driver showing
// score (digits 2..0, leading zeros blanked) and lives (digit 3).
module score_display
    import mole_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int BLINK_DIV   = 25000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] score,
    input  logic [1:0] lives,
    input  logic [2:0] state,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);
    localparam int RW = $clog2(REFRESH_DIV + 1);
    localparam int BW = $clog2(BLINK_DIV + 1);

    logic [RW-1:0] ref_cnt_q, ref_cnt_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [6:0]    last_q, last_d;
    logic [3:0]    hund_q, hund_d, tens_q, tens_d, ones_q, ones_d;
    logic          blink_on_q, blink_on_d, was_end_q, was_end_d;
    logic [3:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;
    logic          start, busy, done, ref_wrap, blink_wrap, is_end, end_entry, vis;
    logic [3:0]    bcd_h, bcd_t, bcd_o;

    bin2bcd_seq u_conv (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .bin   (score),
        .busy  (busy),
        .done  (done),
        .hund  (bcd_h),
        .tens  (bcd_t),
        .ones  (bcd_o)
    );

    always_comb begin
        start = !busy && score != last_q;
        last_d = start ? score : last_q;
        {hund_d, tens_d, ones_d} = done ? {bcd_h, bcd_t, bcd_o} : {hund_q, tens_q, ones_q};
        ref_wrap = ref_cnt_q == RW'(REFRESH_DIV - 1);
        ref_cnt_d = ref_wrap ? '0 : ref_cnt_q + RW'(1);
        idx_d = ref_wrap ? idx_q + 2'd1 : idx_q;
        is_end = state == ST_ENDSCREEN;
        end_entry = is_end && !was_end_q;
        was_end_d = is_end;
        blink_wrap = blink_cnt_q == BW'(BLINK_DIV - 1);
        blink_cnt_d = (end_entry || blink_wrap) ? '0 : blink_cnt_q + BW'(1);
        blink_on_d = end_entry ? 1'b1 : blink_wrap ? !blink_on_q : blink_on_q;
        // next-state blink phase keeps visible/blank halves exactly BLINK_DIV outputs long
        vis = !is_end || blink_on_d;
        an_d = ~(4'b0001 << idx_q);
        dp_d = state == ST_IDLE || idx_q != 2'd3;
        seg_d = (state == ST_IDLE) ? SEG_DASH
              : (idx_q == 2'd3)    ? seg_font({2'b00, lives})
              : !vis               ? SEG_BLANK
              : (idx_q == 2'd2)    ? ((hund_q == 4'd0) ? SEG_BLANK : seg_font(hund_q))
              : (idx_q == 2'd1)    ? ((hund_q == 4'd0 && tens_q == 4'd0) ? SEG_BLANK : seg_font(tens_q))
              : seg_font(ones_q);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ref_cnt_q   <= '0;
            blink_cnt_q <= '0;
            idx_q       <= '0;
            last_q      <= '0;
            hund_q      <= '0;
            tens_q      <= '0;
            ones_q      <= '0;
            blink_on_q  <= 1'b1;
            was_end_q   <= 1'b0;
            an_q        <= 4'b1111;
            seg_q       <= SEG_BLANK;
            dp_q        <= 1'b1;
        end else begin
            ref_cnt_q   <= ref_cnt_d;
            blink_cnt_q <= blink_cnt_d;
            idx_q       <= idx_d;
            last_q      <= last_d;
            hund_q      <= hund_d;
            tens_q      <= tens_d;
            ones_q      <= ones_d;
            blink_on_q  <= blink_on_d;
            was_end_q   <= was_end_d;
            an_q        <= an_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;
endmodule

// File: tb/tb_score_display.sv
// tb_score_display: randomized scoreboard bench; stimulus queues per-cycle
// expected digit tables, a negedge monitor pops one per cycle and compares.
module tb_score_display;
    localparam int RD = 4;
    localparam int BD = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] score = 7'd0;
    logic [1:0] lives = 2'd3;
    logic [2:0] state = 3'd1;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    int         checks = 0;
    int         failures = 0;

    typedef struct {
        string       tag;
        logic [27:0] a0;
        logic [27:0] a1;
        logic [27:0] a2;
        int          nalt;
        logic [3:0]  dpn;
        int          an_idx;
    } item_t;

    item_t q[$];

    score_display #(.REFRESH_DIV(RD), .BLINK_DIV(BD)) dut (
        .clk   (clk),
        .reset (reset),
        .score (score),
        .lives (lives),
        .state (state),
        .an    (an),
        .seg   (seg),
        .dp    (dp)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] font(int d);
        case (d)
            0: return 7'h40;
            1: return 7'h79;
            2: return 7'h24;
            3: return 7'h30;
            4: return 7'h19;
            5: return 7'h12;
            6: return 7'h02;
            7: return 7'h78;
            8: return 7'h00;
            9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    // Expected four-slot table {slot3, slot2, slot1, slot0} from decimal arithmetic.
    function automatic logic [27:0] frame(int sc, int lv, int st, bit vis);
        int h = sc / 100;
        int t = (sc / 10) % 10;
        int o = sc % 10;
        if (st == 0) return {4{7'h3F}};
        return {font(lv),
                (vis && h != 0) ? font(h) : 7'h7F,
                (vis && (h != 0 || t != 0)) ? font(t) : 7'h7F,
                vis ? font(o) : 7'h7F};
    endfunction

    task automatic push(string tag, int n, bit scan, logic [27:0] a0, logic [27:0] a1,
                        logic [27:0] a2, int nalt, int st);
        item_t it;
        for (int k = 0; k < n; k++) begin
            it.tag = tag;
            it.a0 = a0;
            it.a1 = a1;
            it.a2 = a2;
            it.nalt = nalt;
            it.dpn = (st == 0) ? 4'b1111 : 4'b0111;
            it.an_idx = scan ? (k / 4) % 4 : -1;
            q.push_back(it);
        end
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() > 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        if (q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain: %0d items never consumed", q.size());
            q.delete();
        end
    endtask

    task automatic check_reset(string tag);
        checks++;
        if (an !== 4'b1111 || seg !== 7'h7F || dp !== 1'b1) begin
            failures++;
            $display("FAIL %s: an=%b seg=%b dp=%b, expected an=1111 seg=1111111 dp=1", tag, an, seg, dp);
        end
    endtask

    // Change inputs, then check a full scan starting 9 cycles after the change.
    task automatic apply(string tag, int sc, int lv, int st);
        logic [27:0] f;
        @(posedge clk);
        #1;
        score = 7'(sc);
        lives = 2'(lv);
        state = 3'(st);
        repeat (9) @(posedge clk);
        @(negedge clk);
        #1;
        f = frame(sc, lv, st, 1'b1);
        push(tag, 16, 1'b0, f, f, f, 1, st);
        drain();
    endtask

    always @(negedge clk) begin : monitor
        item_t it;
        int idx;
        int s;
        bit ok;
        if (q.size() > 0) begin
            it = q.pop_front();
            idx = (an == 4'b1110) ? 0 : (an == 4'b1101) ? 1 : (an == 4'b1011) ? 2 : (an == 4'b0111) ? 3 : -1;
            ok = idx >= 0 && (it.an_idx < 0 || it.an_idx == idx);
            if (ok)
                ok = dp === it.dpn[idx] &&
                     (seg === it.a0[7*idx +: 7] ||
                      (it.nalt > 1 && seg === it.a1[7*idx +: 7]) ||
                      (it.nalt > 2 && seg === it.a2[7*idx +: 7]));
            checks++;
            if (!ok) begin
                failures++;
                s = (idx < 0) ? 0 : idx;
                $display("FAIL %s: an=%b seg=%b dp=%b, expected slot %0d (any=-1) seg=%b dp=%b",
                         it.tag, an, seg, dp, it.an_idx, it.a0[7*s +: 7], it.dpn[s]);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [27:0] f0, f1, f2;
        int bc;
        int sc, lv, st, p;
        #1 reset = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check_reset("reset_hold");
        end
        // release: exact scan order with score 0, lives 3
        @(negedge clk);
        #1 reset = 1'b1;
        f0 = frame(0, 3, 1, 1'b1);
        push("scan_after_reset", 16, 1'b1, f0, f0, f0, 1, 1);
        drain();

        // 127 / lives 2 with converter busy-window measurement
        @(posedge clk);
        #1;
        score = 7'd127;
        lives = 2'd2;
        bc = 0;
        repeat (12) begin
            @(negedge clk);
            bc += int'(dut.u_conv.busy);
        end
        checks++;
        if (bc != 7) begin
            failures++;
            $display("FAIL busy_cycles: got %0d, expected 7", bc);
        end
        f0 = frame(127, 2, 1, 1'b1);
        push("score127", 16, 1'b0, f0, f0, f0, 1, 1);
        drain();

        apply("score5", 5, 2, 1);
        apply("score100", 100, 1, 1);
        apply("idle", 100, 1, 0);
        apply("score42", 42, 1, 1);

        // ENDSCREEN blink: 16 visible, 16 blank, 16 visible
        @(posedge clk);
        #1 state = 3'd3;
        @(negedge clk);
        #1;
        for (int k = 0; k < 48; k++) begin
            f0 = frame(42, 1, 3, ((k / 16) % 2) == 0);
            push("blink", 1, 1'b0, f0, f0, f0, 1, 3);
        end
        drain();

        for (int r = 0; r < 20; r++) begin
            sc = int'($urandom_range(127));
            lv = int'($urandom_range(3));
            p = int'($urandom_range(6));
            st = (p < 3) ? p : p + 1;
            apply("random", sc, lv, st);
        end

        // back-to-back changes 10 -> 99: only whole values may appear
        apply("pre_b2b", 5, 3, 1);
        @(posedge clk);
        #1 score = 7'd10;
        @(posedge clk);
        #1 score = 7'd99;
        @(negedge clk);
        #1;
        push("b2b_window", 20, 1'b0, frame(5, 3, 1, 1'b1), frame(10, 3, 1, 1'b1), frame(99, 3, 1, 1'b1), 3, 1);
        drain();
        @(negedge clk);
        #1;
        f0 = frame(99, 3, 1, 1'b1);
        push("b2b_final", 16, 1'b0, f0, f0, f0, 1, 1);
        drain();

        // reset during conversion
        @(posedge clk);
        #1 score = 7'd77;
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        #1 check_reset("reset_mid_conv");
        @(negedge clk);
        check_reset("reset_mid_conv_hold");
        #1 reset = 1'b1;
        f1 = frame(0, 3, 1, 1'b1);
        f2 = frame(77, 3, 1, 1'b1);
        push("scan_after_conv_reset", 16, 1'b1, f1, f2, f2, 2, 1);
        drain();
        @(negedge clk);
        #1 push("reconvert77", 16, 1'b0, f2, f2, f2, 1, 1);
        drain();

        // reset mid-scan
        repeat ($urandom_range(3, 9)) @(posedge clk);
        #2 reset = 1'b0;
        #1 check_reset("reset_mid_scan");
        @(negedge clk);
        #1 reset = 1'b1;
        push("scan_after_scan_reset", 16, 1'b1, f1, f2, f2, 2, 1);
        drain();
        @(negedge clk);
        #1 push("reconvert77_b", 16, 1'b0, f2, f2, f2, 1, 1);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
